// File: rtl/sensor_conditioner.sv
// Vehicle-loop conditioner: synchroniser, debounce/hold FSM and saturating arrival counter.
// Defining SENSOR_STUCK_DET_EN adds the stuck-loop detector that drives stuck_fault.
module sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 8,
   parameter int STUCK_CYCLES    = 1000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       raw_sensor,
   output logic       sensor,
   output logic [7:0] vehicle_count,
   output logic       stuck_fault
);

   typedef enum logic [1:0] {IDLE, QUAL, PRESENT, HOLD} state_t;

   localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       meta;
   logic       raw_s;
   logic       stuck_hit;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (clr) begin
         meta  <= 1'b0;
         raw_s <= 1'b0;
      end else begin
         meta  <= raw_sensor;
         raw_s <= meta;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state         <= IDLE;
         cnt           <= '0;
         sensor        <= 1'b0;
         vehicle_count <= '0;
      end else if (stuck_fault || stuck_hit) begin
         // Faulted: park in IDLE and reuse cnt to time the loop's low period.
         state  <= IDLE;
         sensor <= 1'b0;
         if (stuck_hit || raw_s || cnt == DEB_LAST)
            cnt <= '0;
         else
            cnt <= cnt + 8'd1;
      end else begin
         case (state)
            IDLE: begin
               sensor <= 1'b0;
               if (raw_s) begin
                  state <= QUAL;
                  cnt   <= 8'd1;
               end
            end
            QUAL: begin
               if (!raw_s) begin
                  state  <= IDLE;
                  sensor <= 1'b0;
               end else if (cnt == DEB_LAST) begin
                  state         <= PRESENT;
                  sensor        <= 1'b1;
                  vehicle_count <= sat_inc(vehicle_count);
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            PRESENT: begin
               sensor <= 1'b1;
               if (!raw_s) begin
                  state <= HOLD;
                  cnt   <= '0;
               end
            end
            HOLD: begin
               // A returning loop is the same vehicle: back to PRESENT without counting.
               if (raw_s) begin
                  state  <= PRESENT;
                  sensor <= 1'b1;
               end else if (cnt == HOLD_LAST) begin
                  state  <= IDLE;
                  sensor <= 1'b0;
               end else begin
                  cnt    <= cnt + 8'd1;
                  sensor <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               sensor <= 1'b0;
            end
         endcase
      end
   end

`ifdef SENSOR_STUCK_DET_EN
   localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYCLES - 1);

   logic [15:0] stuck_cnt;
   logic        occupied;

   assign occupied  = (state == PRESENT) || (state == HOLD);
   assign stuck_hit = !stuck_fault && occupied && (stuck_cnt == STUCK_LAST);

   always_ff @(posedge clk) begin
      if (clr) begin
         stuck_cnt   <= '0;
         stuck_fault <= 1'b0;
      end else begin
         if (stuck_hit)
            stuck_fault <= 1'b1;
         else if (stuck_fault && !raw_s && cnt == DEB_LAST)
            stuck_fault <= 1'b0;

         if (occupied && !stuck_hit)
            stuck_cnt <= stuck_cnt + 16'd1;
         else
            stuck_cnt <= '0;
      end
   end
`else
   assign stuck_hit   = 1'b0;
   assign stuck_fault = 1'b0;
`endif

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Upstream stage for the traffic light controller. It synchronises and debounces the raw small-road vehicle-loop input and extends presence with a hold time. It produces the clean, registered `sensor` level that the controller's state machine consumes, and counts qualified vehicle arrivals. An optional stuck-loop detector protects highway traffic from a failed-on loop.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised-high cycles required to qualify a vehicle; legal range 2..255.
- `HOLD_CYCLES`, 8: cycles `sensor` stays high after the loop goes low; legal range 1..255.
- `STUCK_CYCLES`, 1000: continuous-presence limit for the stuck detector; legal range 2..65535; used only with `SENSOR_STUCK_DET_EN`.
- `clk`  input  1  sole clock; all logic is on the rising edge.
- `clr`  input  1  synchronous, active-high reset.
- `raw_sensor`  input  1  asynchronous loop detector input.
- `sensor`  output  1  registered, conditioned vehicle presence, sent to the controller.
- `vehicle_count`  output  8  saturating count of qualified arrivals.
- `stuck_fault`  output  1  sticky stuck-loop flag.

## Operation
- Synchroniser: two flops, `raw_sensor` → `meta` → `raw_s`. The FSM uses only `raw_s`. Reset value of both flops is 0.
- FSM states are IDLE, QUAL, PRESENT and HOLD. An 8-bit counter `cnt` is shared between them.
- IDLE:
  - If `raw_s`=1, go to QUAL with `cnt`=1.
  - Otherwise stay in IDLE.
- QUAL:
  - If `raw_s`=0, go to IDLE.
  - Else if `cnt`==DEBOUNCE_CYCLES-1, go to PRESENT and increment `vehicle_count`.
  - Else increment `cnt`.
- PRESENT:
  - If `raw_s`=0, go to HOLD with `cnt`=0.
  - Otherwise stay in PRESENT.
- HOLD:
  - If `raw_s`=1, return to PRESENT. This is the same vehicle, so there is no count increment.
  - Else if `cnt`==HOLD_CYCLES-1, go to IDLE.
  - Else increment `cnt`.
- `sensor` is a flop loaded with the next-state decode, so `sensor`=1 exactly when the state register is PRESENT or HOLD. It has no combinational path from `raw_sensor`.
- `vehicle_count` saturates at 255. An arrival while it is at 255 leaves it at 255.
- Reset: `clr`=1 at a clock edge forces the following, regardless of the current state, including mid-QUAL or mid-HOLD:
  - state IDLE, `cnt` 0;
  - `sensor` 0, `vehicle_count` 0, `stuck_fault` 0;
  - synchroniser flops 0, stuck counter 0.

## Timing
- Rising edge: if `raw_sensor` is first sampled high at edge k and stays high, `sensor` goes high after edge k+DEBOUNCE_CYCLES+1. With the default, that is edge k+5.
- Falling edge: if `raw_sensor` is first sampled low at edge m and stays low, `sensor` goes low after edge m+HOLD_CYCLES+2. With the default, that is edge m+10.
- Glitch rejection: a high pulse of DEBOUNCE_CYCLES-1 or fewer cycles never raises `sensor` and never changes `vehicle_count`.
- `vehicle_count` updates on the same edge that `sensor` rises.
- A loop dropout shorter than HOLD_CYCLES+1 cycles keeps `sensor` high with no glitch and no extra count.
- `clr` and a qualifying event on the same edge: `clr` wins.

## Configuration
- Macro: `SENSOR_STUCK_DET_EN`.
- Defined:
  - A 16-bit stuck counter increments every cycle in PRESENT or HOLD and clears in IDLE and QUAL.
  - When it reaches STUCK_CYCLES, `stuck_fault` is set on that edge and the FSM is forced to IDLE, so `sensor`=0 on the same edge.
  - While `stuck_fault`=1 the FSM stays in IDLE.
  - `stuck_fault` clears, and the FSM resumes, after `raw_s` is 0 for DEBOUNCE_CYCLES consecutive cycles. It also clears on `clr`.
- Undefined:
  - There is no stuck counter.
  - `stuck_fault` is tied to 0 and the port remains.
  - STUCK_CYCLES is ignored.

## Test plan
- Reset and clean arrival/departure (D=4, H=8):
  - After `clr`, all outputs are 0.
  - `raw_sensor` high from edge 10 → `sensor` high after edge 15 and `vehicle_count`=1.
  - `raw_sensor` low from edge 40 → `sensor` low after edge 50.
- Glitch rejection: 3-cycle high pulse → `sensor` stays 0 and `vehicle_count` stays 0. A 4-cycle pulse → `sensor` high after 5 edges, then low H+2 edges after the fall, and count=1.
- Dropout bridging: while present, a 5-cycle low gap → `sensor` stays continuously 1 and `vehicle_count` does not increment. A 10-cycle gap → `sensor` falls, and the next qualified arrival increments the count.
- Saturation: 260 qualified arrivals → `vehicle_count` reads 255 and holds.
- Mid-operation reset: assert `clr` for 1 cycle during HOLD → on the next edge `sensor`=0, `vehicle_count`=0 and state is IDLE. With `raw_sensor` still high, re-qualification takes DEBOUNCE_CYCLES+1 edges again.
- With `SENSOR_STUCK_DET_EN` (STUCK_CYCLES=20):
  - `raw_sensor` held high → `stuck_fault`=1 and `sensor`=0 20 edges after `sensor` rose.
  - Both hold while `raw_sensor` stays high.
  - After `raw_sensor` is low for 6 edges (2 sync + D=4), `stuck_fault`=0 and normal qualification resumes.
